// File: rtl/mult_booth_if.sv
// rtl/mult_booth_if.sv - start/done handshake and operand/product bundle for mult_booth
interface mult_booth_if #(parameter int WIDTH = 32);
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             doMult;
   logic [WIDTH-1:0] outHi;
   logic [WIDTH-1:0] outLo;
   logic             busy;
   logic             endMult;

   modport master (output A, B, doMult, input outHi, outLo, busy, endMult);
   modport slave  (input A, B, doMult, output outHi, outLo, busy, endMult);
endinterface

// File: rtl/mult_booth.sv
// rtl/mult_booth.sv - sequential signed radix-2 Booth multiplier, one step per clock
module mult_booth #(
   parameter int WIDTH = 32
) (
   input  logic         clock,
   input  logic         resetMult,
   mult_booth_if.slave  mb
);
   localparam int PW = 2*WIDTH + 2;
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state;
   state_t          state_nx;
   logic [WIDTH:0]  mcand;
   logic [PW-1:0]   p;
   logic [CW-1:0]   count;
   logic [WIDTH:0]  acc_sum;
   logic [PW-1:0]   p_step;
   logic            last_step;
   logic [WIDTH-1:0] out_hi;
   logic [WIDTH-1:0] out_lo;

   // P = {acc (WIDTH+1), multiplier (WIDTH), q-1}; extra acc bit keeps -2^(WIDTH-1) in range
   always_comb begin
      acc_sum = p[PW-1:WIDTH+1];
      case (p[1:0])
         2'b01:   acc_sum = p[PW-1:WIDTH+1] + mcand;
         2'b10:   acc_sum = p[PW-1:WIDTH+1] - mcand;
         default: acc_sum = p[PW-1:WIDTH+1];
      endcase
      p_step    = {acc_sum[WIDTH], acc_sum, p[WIDTH:1]};
      last_step = (count == CW'(1));
   end

   always_ff @(posedge clock or negedge resetMult) begin
      if (!resetMult) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (mb.doMult) state_nx = RUN;
         RUN:     if (last_step) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetMult) begin
      if (!resetMult) begin
         mcand  <= '0;
         p      <= '0;
         count  <= '0;
         out_hi <= '0;
         out_lo <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (mb.doMult) begin
                  mcand <= {mb.A[WIDTH-1], mb.A};
                  p     <= {{(WIDTH+1){1'b0}}, mb.B, 1'b0};
                  count <= CW'(WIDTH);
               end
            end
            RUN: begin
               p     <= p_step;
               count <= count - CW'(1);
               // outputs only change on completion so Hi/Lo hold across a new start
               if (last_step) begin
                  out_hi <= p_step[2*WIDTH:WIDTH+1];
                  out_lo <= p_step[WIDTH:1];
               end
            end
            default: ;
         endcase
      end
   end

   assign mb.outHi   = out_hi;
   assign mb.outLo   = out_lo;
   assign mb.busy    = (state == RUN);
   assign mb.endMult = (state == DONE);
endmodule

// File: tb/tb_mult_booth.sv
// tb/tb_mult_booth.sv - directed self-checking bench for mult_booth
module tb_mult_booth;
   logic clock;
   logic resetMult;
   int   tests;
   int   fails;

   mult_booth_if #(.WIDTH(32)) mb ();

   mult_booth #(.WIDTH(32)) dut (
      .clock     (clock),
      .resetMult (resetMult),
      .mb        (mb.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_mult(input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input string tag);
      int   n;
      logic busy_ok;
      n       = 0;
      busy_ok = 1'b1;
      mb.A      = a;
      mb.B      = b;
      mb.doMult = 1'b1;
      @(posedge clock); #1;
      mb.doMult = 1'b0;
      while (mb.endMult !== 1'b1 && n < 40) begin
         if (mb.busy !== 1'b1) busy_ok = 1'b0;
         @(posedge clock); #1;
         n++;
      end
      chk({tag, " latency"}, 64'(n), 64'd32);
      chk({tag, " busy_run"}, 64'(busy_ok), 64'd1);
      chk({tag, " busy_done"}, 64'(mb.busy), 64'd0);
      chk({tag, " product"}, {mb.outHi, mb.outLo}, exp);
      @(posedge clock); #1;
      chk({tag, " end_pulse"}, 64'(mb.endMult), 64'd0);
   endtask

   initial begin
      int          pulses;
      int          done_at;
      logic [63:0] res;

      tests = 0;
      fails = 0;
      resetMult = 1'b0;
      mb.A      = '0;
      mb.B      = '0;
      mb.doMult = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      chk("rst outs", {mb.outHi, mb.outLo}, 64'd0);
      chk("rst busy", 64'(mb.busy), 64'd0);
      chk("rst end", 64'(mb.endMult), 64'd0);
      resetMult = 1'b1;
      @(posedge clock); #1;

      do_mult(32'd7, 32'd5, 64'h00000000_00000023, "7x5");
      do_mult(32'hFFFFFFFD, 32'd4, 64'hFFFFFFFF_FFFFFFF4, "-3x4");
      do_mult(32'd4, 32'hFFFFFFFD, 64'hFFFFFFFF_FFFFFFF4, "4x-3");
      do_mult(32'h80000000, 32'h80000000, 64'h40000000_00000000, "minxmin");
      do_mult(32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001, "-1x-1");
      do_mult(32'h7FFFFFFF, 32'h80000000, 64'hC0000000_80000000, "maxxmin");

      // operand and start changes during RUN must be ignored
      mb.A = 32'd6; mb.B = 32'd7; mb.doMult = 1'b1;
      @(posedge clock); #1;
      mb.doMult = 1'b0;
      pulses = 0; done_at = 0; res = '0;
      for (int k = 1; k <= 40; k++) begin
         if (k == 10) begin mb.A = 32'd1; mb.B = 32'd1; mb.doMult = 1'b1; end
         @(posedge clock); #1;
         if (k == 10) mb.doMult = 1'b0;
         if (k == 20) chk("ign hold", {mb.outHi, mb.outLo}, 64'hC0000000_80000000);
         if (mb.endMult === 1'b1) begin
            pulses++;
            if (pulses == 1) begin done_at = k; res = {mb.outHi, mb.outLo}; end
         end
      end
      chk("ign pulses", 64'(pulses), 64'd1);
      chk("ign latency", 64'(done_at), 64'd32);
      chk("ign product", res, 64'd42);

      // asynchronous reset mid-operation
      mb.A = 32'd1000; mb.B = 32'd1000; mb.doMult = 1'b1;
      @(posedge clock); #1;
      mb.doMult = 1'b0;
      repeat (15) @(posedge clock);
      #3;
      resetMult = 1'b0;
      #1;
      chk("arst outs", {mb.outHi, mb.outLo}, 64'd0);
      chk("arst busy", 64'(mb.busy), 64'd0);
      chk("arst end", 64'(mb.endMult), 64'd0);
      repeat (2) @(posedge clock);
      #1;
      resetMult = 1'b1;
      pulses = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clock); #1;
         if (mb.endMult === 1'b1 || mb.busy === 1'b1) pulses++;
      end
      chk("arst quiet", 64'(pulses), 64'd0);
      do_mult(32'd2, 32'd3, 64'd6, "2x3");

      // back-to-back with doMult held high
      mb.A = 32'd9; mb.B = 32'd9; mb.doMult = 1'b1;
      @(posedge clock); #1;
      mb.A = 32'hFFFFFFF7;
      pulses = 0;
      for (int k = 1; k <= 66; k++) begin
         @(posedge clock); #1;
         if (mb.endMult === 1'b1) pulses++;
         if (k == 32) begin
            chk("b2b end1", 64'(mb.endMult), 64'd1);
            chk("b2b prod1", {mb.outHi, mb.outLo}, 64'd81);
         end
         if (k == 33) chk("b2b idle", 64'(mb.busy), 64'd0);
         if (k == 34) chk("b2b restart", 64'(mb.busy), 64'd1);
         if (k == 50) chk("b2b hold", {mb.outHi, mb.outLo}, 64'd81);
         if (k == 66) begin
            mb.doMult = 1'b0;
            chk("b2b end2", 64'(mb.endMult), 64'd1);
            chk("b2b prod2", {mb.outHi, mb.outLo}, 64'hFFFFFFFF_FFFFFFAF);
         end
      end
      chk("b2b pulses", 64'(pulses), 64'd2);
      repeat (3) @(posedge clock);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
